// File: rtl/input_conditioner.sv
// Board input conditioner: synchronises and debounces KEY/SW pins for the Nios II PIOs,
// and emits per-key press/release pulses with optional auto-repeat.

// One channel of 2-FF synchroniser plus debounce window. The debounced level register is
// owned by the caller so key event pulses can be registered on the same edge as the level.
module ic_debounce #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic level_q,
    output logic level_d
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    // Any return of sync to the current level clears the count, so glitches restart the window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
endmodule

// One pushbutton: debounce, active-low level register and press/repeat/release FSM.
module ic_key #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int            RMAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW        = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          fall, rise;

    ic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw_n),
        .level_q(level_q),
        .level_d(level_d)
    );

    assign fall = level_q & ~level_d;
    assign rise = ~level_q & level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // A release overrides any repeat tick landing on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (rise) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        press_d = 1'b1;
                        cnt_d   = '0;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (REPEAT_EN != 0) begin
                        if (cnt_q == DLY_LAST) begin
                            press_d = 1'b1;
                            cnt_d   = '0;
                            state_d = REPEAT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (cnt_q == RATE_LAST) begin
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

module input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 18,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_KEYS-1:0] key_raw_n,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_KEYS-1:0] pushbuttons_export,
    output logic [N_SW-1:0]   sw_sliders_export,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);
    logic [N_SW-1:0] sw_level_q, sw_level_d;

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_key
            ic_key #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_EN      (REPEAT_EN),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_key (
                .clk      (clk_clk),
                .rst_n    (reset_reset_n),
                .raw_n    (key_raw_n[i]),
                .level_o  (pushbuttons_export[i]),
                .press_o  (key_press[i]),
                .release_o(key_release[i])
            );
        end
        for (genvar i = 0; i < N_SW; i++) begin : g_sw
            ic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
                .clk    (clk_clk),
                .rst_n  (reset_reset_n),
                .raw    (sw_raw[i]),
                .level_q(sw_level_q[i]),
                .level_d(sw_level_d[i])
            );
        end
    endgenerate

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) sw_level_q <= '0;
        else                sw_level_q <= sw_level_d;
    end

    assign sw_sliders_export = sw_level_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: level vector table plus scoreboarded press/release pulses,
// with hand-written glitch, repeat, bounce and reset-during-repeat sequences.
module tb_input_conditioner;
    localparam int NK = 4;
    localparam int NS = 18;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n;
    logic [NS-1:0] sw;
    logic [NK-1:0] pb, kp, kr;
    logic [NS-1:0] swo;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } ev_t;

    typedef struct {
        logic [NK-1:0] key_n;
        logic [NS-1:0] sw;
        logic [NK-1:0] exp_pb;
        logic [NS-1:0] exp_sw;
    } vec_t;

    ev_t  sb[$];
    ev_t  mon_e;
    vec_t vecs[7];

    input_conditioner #(
        .N_KEYS(NK), .N_SW(NS), .DEBOUNCE_CYCLES(8),
        .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .key_raw_n         (key_n),
        .sw_raw            (sw),
        .pushbuttons_export(pb),
        .sw_sliders_export (swo),
        .key_press         (kp),
        .key_release       (kr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r);
        ev_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    // Every cycle: either the scheduled pulse pattern, or no pulse at all.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_event: expected pulse at cycle %0d, now %0d", sb[0].cyc, cyc);
            mon_e = sb.pop_front();
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("press_pulse", 32'(kp), 32'(mon_e.press));
            chk("release_pulse", 32'(kr), 32'(mon_e.rel));
        end else begin
            chk("no_pulse", 32'({kp, kr}), 32'd0);
        end
    end

    initial begin
        int            c, r;
        logic [NK-1:0] prev_k;
        logic [NS-1:0] prev_sw;

        vecs[0] = '{4'hF, 18'h2A5A5, 4'hF, 18'h2A5A5};
        vecs[1] = '{4'hE, 18'h00001, 4'hE, 18'h00001};
        vecs[2] = '{4'hF, 18'h3FFFF, 4'hF, 18'h3FFFF};
        vecs[3] = '{4'h0, 18'h15555, 4'h0, 18'h15555};
        vecs[4] = '{4'hF, 18'h00000, 4'hF, 18'h00000};
        vecs[5] = '{4'h5, 18'h2AAAA, 4'h5, 18'h2AAAA};
        vecs[6] = '{4'hF, 18'h2AAAA, 4'hF, 18'h2AAAA};

        key_n = '1;
        sw    = '0;
        repeat (3) @(negedge clk);
        chk("rst_pb", 32'(pb), 32'hF);
        chk("rst_sw", 32'(swo), 32'h0);

        // Switches held through reset release appear exactly at edge 10.
        sw    = 18'h2A5A5;
        rst_n = 1'b1;
        r     = cyc;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("sw_latency", 32'(swo), (cyc >= r + 10) ? 32'h2A5A5 : 32'h0);
            chk("pb_idle", 32'(pb), 32'hF);
        end

        prev_k  = 4'hF;
        prev_sw = 18'h2A5A5;
        for (int i = 0; i < 7; i++) begin
            c     = cyc;
            key_n = vecs[i].key_n;
            sw    = vecs[i].sw;
            if (prev_k != vecs[i].key_n)
                expect_ev(c + 10, prev_k & ~vecs[i].key_n, ~prev_k & vecs[i].key_n);
            repeat (9) @(negedge clk);
            chk("vec_pb_hold", 32'(pb), 32'(prev_k));
            chk("vec_sw_hold", 32'(swo), 32'(prev_sw));
            @(negedge clk);
            chk("vec_pb", 32'(pb), 32'(vecs[i].exp_pb));
            chk("vec_sw", 32'(swo), 32'(vecs[i].exp_sw));
            repeat (2) @(negedge clk);
            prev_k  = vecs[i].exp_pb;
            prev_sw = vecs[i].exp_sw;
        end

        // 5-clock glitch on key 0.
        key_n[0] = 1'b0;
        repeat (5) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch_pb", 32'(pb), 32'hF);

        // Key 1 held: press, repeats at +20/+25, release collides with +30 repeat.
        c     = cyc;
        key_n = 4'hD;
        expect_ev(c + 10, 4'h2, 4'h0);
        expect_ev(c + 30, 4'h2, 4'h0);
        expect_ev(c + 35, 4'h2, 4'h0);
        expect_ev(c + 40, 4'h0, 4'h2);
        repeat (10) @(negedge clk);
        chk("rep_pb_press", 32'(pb), 32'hD);
        repeat (20) @(negedge clk);
        key_n = 4'hF;
        repeat (10) @(negedge clk);
        chk("rep_pb_release", 32'(pb), 32'hF);
        repeat (30) @(negedge clk);

        // Key 3 bouncing every 3 clocks, then settling low.
        for (int t = 0; t < 14; t++) begin
            key_n[3] = (t % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk);
        end
        chk("bounce_pb_idle", 32'(pb), 32'hF);
        c        = cyc;
        key_n[3] = 1'b0;
        expect_ev(c + 10, 4'h8, 4'h0);
        repeat (10) @(negedge clk);
        chk("bounce_pb", 32'(pb), 32'h7);
        repeat (2) @(negedge clk);
        key_n[3] = 1'b1;
        expect_ev(cyc + 10, 4'h0, 4'h8);
        repeat (12) @(negedge clk);

        // Key 2 held into REPEAT, then reset asserted and released with key still held.
        c        = cyc;
        key_n[2] = 1'b0;
        expect_ev(c + 10, 4'h4, 4'h0);
        expect_ev(c + 30, 4'h4, 4'h0);
        expect_ev(c + 35, 4'h4, 4'h0);
        repeat (37) @(negedge clk);
        chk("pre_rst_pb", 32'(pb), 32'hB);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("async_rst_pb", 32'(pb), 32'hF);
        chk("async_rst_sw", 32'(swo), 32'h0);
        chk("async_rst_pulses", 32'({kp, kr}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r     = cyc;
        expect_ev(r + 10, 4'h4, 4'h0);
        repeat (9) @(negedge clk);
        chk("post_rst_pb_hold", 32'(pb), 32'hF);
        @(negedge clk);
        chk("post_rst_pb", 32'(pb), 32'hB);
        chk("post_rst_sw", 32'(swo), 32'h2AAAA);
        repeat (2) @(negedge clk);
        key_n[2] = 1'b1;
        expect_ev(cyc + 10, 4'h0, 4'h4);
        repeat (15) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
